// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32 control sequencer: opcodes, state
// encodings, ALU operand/op select codes and the latched instruction class.
package rv_ctrl_pkg;

  // Major opcodes decoded by the sequencer (IR[6:0])
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Sequencer states, 4-bit encoding exposed on state_o
  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_FETCH   = 4'd1;
  localparam logic [3:0] ST_DECODE  = 4'd2;
  localparam logic [3:0] ST_EXEC_R  = 4'd3;
  localparam logic [3:0] ST_ALU_WB  = 4'd4;
  localparam logic [3:0] ST_ADDR    = 4'd5;
  localparam logic [3:0] ST_MEM     = 4'd6;
  localparam logic [3:0] ST_LOAD_WB = 4'd7;
  localparam logic [3:0] ST_BRANCH  = 4'd8;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand B select
  localparam logic [1:0] ALUSRCB_RS2  = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM  = 2'b10;

  // Instruction class latched in DECODE, steers the later states
  typedef enum logic [1:0] {
    CLS_R      = 2'd0,
    CLS_LOAD   = 2'd1,
    CLS_STORE  = 2'd2,
    CLS_BRANCH = 2'd3
  } ins_class_e;

endpackage

// File: rtl/rv_perf_counters.sv
// Free-running cycle and retired-instruction counters for the sequencer.
// Only instantiated when RV_PERF_CNT_EN is defined.
module rv_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_en,
  input  logic        retired,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  // Both counters wrap modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (count_en) cycle_count <= cycle_count + 32'd1;
      if (retired) instret_count <= instret_count + 32'd1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32 datapath. Drives the shared
// memory port, IR/PC enables, ALU selects and writeback, with a memory
// wait-state watchdog. Optional perf counters behind macro RV_PERF_CNT_EN.
module multicycle_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic       bus_error,
  output logic       retired,
  output logic [3:0] state_o
`ifdef RV_PERF_CNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
`endif
);

  localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);
  localparam bit         WdEn       = (MEM_TIMEOUT != 0);

  logic [3:0] state_q, state_d;
  ins_class_e cls_q, cls_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_hit;

  // Watchdog fires only when no completion arrives in the expiring cycle
  assign timeout_hit = WdEn && (cnt_q == TimeoutVal) && !mem_ready;
  assign state_o     = state_q;

  // Next-state, watchdog and output decode
  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    cnt_d        = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = ALUSRCB_RS2;
    alu_op       = ALUOP_ADD;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    illegal_op   = 1'b0;
    bus_error    = 1'b0;
    retired      = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        alu_src_b = ALUSRCB_FOUR;
        if (mem_ready) begin
          mem_req  = 1'b1;
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (timeout_hit) begin
          // Drop the request for a cycle and retry the same PC
          bus_error = 1'b1;
        end else begin
          mem_req = 1'b1;
          cnt_d   = WdEn ? cnt_q + 8'd1 : 8'd0;
        end
      end
      ST_DECODE: begin
        alu_src_b = ALUSRCB_IMM;
        case (opcode)
          OPC_RTYPE: begin
            cls_d   = CLS_R;
            state_d = ST_EXEC_R;
          end
          OPC_LOAD: begin
            cls_d   = CLS_LOAD;
            state_d = ST_ADDR;
          end
          OPC_STORE: begin
            cls_d   = CLS_STORE;
            state_d = ST_ADDR;
          end
          OPC_BRANCH: begin
            cls_d   = CLS_BRANCH;
            state_d = ST_BRANCH;
          end
          default: begin
            illegal_op = 1'b1;
            state_d    = ST_FETCH;
          end
        endcase
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        reg_write = 1'b1;
        retired   = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUSRCB_IMM;
        state_d   = ST_MEM;
      end
      ST_MEM: begin
        mem_addr_sel = 1'b1;
        if (mem_ready) begin
          mem_req = 1'b1;
          mem_we  = (cls_q == CLS_STORE);
          if (cls_q == CLS_LOAD) begin
            state_d = ST_LOAD_WB;
          end else begin
            retired = 1'b1;
            state_d = ST_FETCH;
          end
        end else if (timeout_hit) begin
          bus_error = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          mem_req = 1'b1;
          mem_we  = (cls_q == CLS_STORE);
          cnt_d   = WdEn ? cnt_q + 8'd1 : 8'd0;
        end
      end
      ST_LOAD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retired    = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 1'b1;
        pc_write  = branch_taken;
        retired   = 1'b1;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, instruction class and watchdog registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cls_q   <= CLS_R;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef RV_PERF_CNT_EN
  rv_perf_counters u_perf (
    .clk           (clk),
    .rst_n         (rst_n),
    .count_en      (state_q != ST_IDLE),
    .retired       (retired),
    .cycle_count   (cycle_count),
    .instret_count (instret_count)
  );
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed table-driven bench for multicycle_ctrl_fsm (watchdog set to 4).
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] SD = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DEC = 4'd2, S_EXR = 4'd3;
  localparam logic [3:0] S_AWB = 4'd4, S_ADDR = 4'd5, S_MEM = 4'd6, S_LWB = 4'd7;
  localparam logic [3:0] S_BR = 4'd8;

  // Output vector: {req, we, asel, irw, pcw, pcsrc, asa, asb[1:0], aop[1:0],
  //                 rw, m2r, illegal, buserr, retired}
  localparam logic [15:0] O_IDLE  = 16'h0000;
  localparam logic [15:0] O_FRDY  = 16'h9880;
  localparam logic [15:0] O_FWAIT = 16'h8080;
  localparam logic [15:0] O_FTO   = 16'h0082;
  localparam logic [15:0] O_DEC   = 16'h0100;
  localparam logic [15:0] O_DILL  = 16'h0104;
  localparam logic [15:0] O_EXR   = 16'h0240;
  localparam logic [15:0] O_AWB   = 16'h0011;
  localparam logic [15:0] O_ADDR  = 16'h0300;
  localparam logic [15:0] O_MLD   = 16'hA000;
  localparam logic [15:0] O_MSTW  = 16'hE000;
  localparam logic [15:0] O_MSTR  = 16'hE001;
  localparam logic [15:0] O_MTO   = 16'h2002;
  localparam logic [15:0] O_LWB   = 16'h0019;
  localparam logic [15:0] O_BRT   = 16'h0E21;
  localparam logic [15:0] O_BRN   = 16'h0621;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       branch_taken, mem_ready;
  logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       reg_write, mem_to_reg, illegal_op, bus_error, retired;
  logic [3:0] state_o;
  logic [15:0] outv;
`ifdef RV_PERF_CNT_EN
  logic [31:0] cycle_count, instret_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [6:0]  op;
    logic        bt;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] out;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  assign outv = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src_a,
                 alu_src_b, alu_op, reg_write, mem_to_reg, illegal_op, bus_error, retired};

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .illegal_op   (illegal_op),
    .bus_error    (bus_error),
    .retired      (retired),
    .state_o      (state_o)
`ifdef RV_PERF_CNT_EN
    ,
    .cycle_count   (cycle_count),
    .instret_count (instret_count)
`endif
  );

  task automatic add(input logic [6:0] op, input logic bt, input logic mr,
                     input logic [3:0] st, input logic [15:0] out);
    vec_t v;
    v.op = op; v.bt = bt; v.mr = mr; v.st = st; v.out = out;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] st, input logic [15:0] out);
    n_checks++;
    if (state_o !== st || outv !== out) begin
      n_fail++;
      $display("FAIL %s: state got %0d want %0d, outputs got %h want %h",
               name, state_o, st, outv, out);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  initial begin
    // R-type, zero wait
    add(R, 0, 1, S_IDLE, O_IDLE);
    add(R, 0, 1, S_FETCH, O_FRDY);
    add(R, 0, 1, S_DEC, O_DEC);
    add(BAD, 0, 1, S_EXR, O_EXR);
    add(BAD, 0, 1, S_AWB, O_AWB);
    // LOAD with three wait cycles in MEM; opcode garbage after DECODE is ignored
    add(BAD, 0, 1, S_FETCH, O_FRDY);
    add(LD, 0, 1, S_DEC, O_DEC);
    add(BAD, 0, 1, S_ADDR, O_ADDR);
    for (int i = 0; i < 3; i++) add(BAD, 0, 0, S_MEM, O_MLD);
    add(BAD, 0, 1, S_MEM, O_MLD);
    add(BAD, 0, 1, S_LWB, O_LWB);
    // Branch taken, then not taken
    add(BAD, 1, 1, S_FETCH, O_FRDY);
    add(BR, 1, 1, S_DEC, O_DEC);
    add(BAD, 1, 1, S_BR, O_BRT);
    add(BAD, 0, 1, S_FETCH, O_FRDY);
    add(BR, 0, 1, S_DEC, O_DEC);
    add(BAD, 0, 1, S_BR, O_BRN);
    // Illegal opcode
    add(BAD, 0, 1, S_FETCH, O_FRDY);
    add(BAD, 0, 1, S_DEC, O_DILL);
    // STORE, zero wait
    add(BAD, 0, 1, S_FETCH, O_FRDY);
    add(SD, 0, 1, S_DEC, O_DEC);
    add(BAD, 0, 1, S_ADDR, O_ADDR);
    add(BAD, 0, 1, S_MEM, O_MSTR);
    // FETCH watchdog: four wait cycles, one dead cycle with bus_error, retry
    for (int i = 0; i < 4; i++) add(BAD, 0, 0, S_FETCH, O_FWAIT);
    add(BAD, 0, 0, S_FETCH, O_FTO);
    add(BAD, 0, 1, S_FETCH, O_FRDY);
    add(R, 0, 1, S_DEC, O_DEC);
    add(BAD, 0, 1, S_EXR, O_EXR);
    add(BAD, 0, 1, S_AWB, O_AWB);
    // LOAD: ready arrives in the cycle the watchdog would expire
    add(BAD, 0, 1, S_FETCH, O_FRDY);
    add(LD, 0, 1, S_DEC, O_DEC);
    add(BAD, 0, 1, S_ADDR, O_ADDR);
    for (int i = 0; i < 4; i++) add(BAD, 0, 0, S_MEM, O_MLD);
    add(BAD, 0, 1, S_MEM, O_MLD);
    add(BAD, 0, 1, S_LWB, O_LWB);
    // STORE watchdog in MEM
    add(BAD, 0, 1, S_FETCH, O_FRDY);
    add(SD, 0, 1, S_DEC, O_DEC);
    add(BAD, 0, 1, S_ADDR, O_ADDR);
    for (int i = 0; i < 4; i++) add(BAD, 0, 0, S_MEM, O_MSTW);
    add(BAD, 0, 0, S_MEM, O_MTO);
    add(SD, 0, 1, S_FETCH, O_FRDY);

    // Reset held across edges
    rst_n = 1'b0; opcode = R; branch_taken = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold", S_IDLE, O_IDLE);
`ifdef RV_PERF_CNT_EN
    check32("reset_cycle_count", cycle_count, 32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      opcode = vecs[i].op; branch_taken = vecs[i].bt; mem_ready = vecs[i].mr;
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].out);
      @(posedge clk);
      #1;
    end

    // Now in DECODE of a STORE; 51 non-idle cycles and 7 retirements so far
    mem_ready = 1'b1;
    @(negedge clk);
    check("store_decode", S_DEC, O_DEC);
`ifdef RV_PERF_CNT_EN
    check32("cycle_count", cycle_count, 32'd51);
    check32("instret_count", instret_count, 32'd7);
`endif
    @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    check("store_addr", S_ADDR, O_ADDR);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("store_mem_wait", S_MEM, O_MSTW);
    // Asynchronous reset in the middle of the store access
    #1 rst_n = 1'b0;
    #1;
    check("async_reset", S_IDLE, O_IDLE);
`ifdef RV_PERF_CNT_EN
    check32("async_reset_cycle_count", cycle_count, 32'd0);
    check32("async_reset_instret_count", instret_count, 32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check("restart_idle", S_IDLE, O_IDLE);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("restart_fetch", S_FETCH, O_FRDY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle sequencer for the RV32 core datapath.
- Drives one shared memory port (instruction and data), the IR/PC write enables, the ALU operand selects and ALU op, and register-file writeback, one instruction at a time.
- Decodes the same opcode set as the single-cycle control decoder: R-type, LOAD, STORE, BRANCH.
- Sits between the IR opcode field and the datapath muxes/enables, and adds memory wait-state handling.

Parameters:
- MEM_TIMEOUT, 255, max cycles to wait for mem_ready in FETCH/MEM. 0 disables the watchdog. Counter width 8 bits.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0]; sampled only in DECODE
- branch_taken  in  1  ALU comparison result; valid in BRANCH
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write (store)
- mem_addr_sel  out  1  0 = PC, 1 = ALUOut
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+4 (ALU result), 1 = ALUOut (branch target)
- alu_src_a  out  1  0 = PC, 1 = rs1
- alu_src_b  out  2  00 = rs2, 01 = const 4, 10 = imm
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR
- illegal_op  out  1  one-cycle pulse on unknown opcode
- bus_error  out  1  one-cycle pulse on memory timeout
- retired  out  1  one-cycle pulse when an instruction completes
- state_o  out  4  current state, for debug

Behaviour:
- Reset (async, rst_n low): state = IDLE; all outputs 0; timeout counter 0. Applies mid-access: mem_req drops in the same cycle.
- IDLE: all outputs 0. Next state is FETCH unconditionally.
- FETCH:
  - Outputs: mem_req=1, mem_addr_sel=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - If mem_ready: ir_write=1, pc_write=1, pc_src=0; next state DECODE.
  - Else: hold in FETCH.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target computed into ALUOut).
  - 0110011 -> EXEC_R
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> BRANCH
  - Any other opcode -> illegal_op pulse, then FETCH. No register or memory side effects; retired stays 0.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, retired=1 -> FETCH.
- ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM.
- MEM:
  - Outputs: mem_req=1, mem_addr_sel=1, mem_we = (latched opcode is STORE).
  - On mem_ready, LOAD -> LOAD_WB.
  - On mem_ready, STORE -> retired=1, then FETCH.
  - Else: hold in MEM.
- LOAD_WB: reg_write=1, mem_to_reg=1, retired=1 -> FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1, pc_write=branch_taken, retired=1.
  - Next state FETCH.
- Opcode latch: a 2-bit instruction class (R/LOAD/STORE/BRANCH) is latched in DECODE and used in later states. The opcode input is ignored outside DECODE.
- Output timing:
  - Outputs are decoded combinationally from state.
  - ir_write, pc_write and retired are additionally gated by mem_ready / branch_taken as listed above (Mealy).
  - mem_ready is ignored outside FETCH and MEM.
- Latency with zero-wait memory (mem_ready held 1):
  - R-type 4 cycles
  - LOAD 5 cycles
  - STORE 4 cycles
  - BRANCH 3 cycles
  - Each memory wait cycle adds 1 cycle.
- Watchdog (MEM_TIMEOUT > 0):
  - The counter increments each cycle in FETCH/MEM without mem_ready.
  - It clears on any state change.
  - When the count reaches MEM_TIMEOUT: bus_error pulse, mem_req drops, next state FETCH, PC unchanged. FETCH retries the same PC.
- Simultaneous mem_ready and timeout in the same cycle: mem_ready wins; no bus_error.

Optional Feature:
- Macro: RV_PERF_CNT_EN.
- When defined:
  - Adds outputs cycle_count[31:0] and instret_count[31:0].
  - cycle_count increments every cycle when not in IDLE.
  - instret_count increments on retired.
  - Both are reset to 0 by rst_n and wrap modulo 2^32.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package rv_ctrl_pkg holds:
  - opcode constants OPC_RTYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH
  - state enum (IDLE, FETCH, DECODE, EXEC_R, ALU_WB, ADDR, MEM, LOAD_WB, BRANCH; 4-bit encoding)
  - alu_op encodings ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - alu_src_b encodings
- One sub-module, rv_perf_counters, instantiated only under RV_PERF_CNT_EN.

Test Plan:
- Reset, mem_ready=1, opcode=0110011 -> states IDLE, FETCH, DECODE, EXEC_R, ALU_WB. reg_write=1 only in ALU_WB. retired pulses once at cycle 4 after FETCH entry.
- opcode=0000011, mem_ready low 3 cycles in MEM -> mem_req=1, mem_addr_sel=1, mem_we=0 held 4 cycles. Then LOAD_WB with mem_to_reg=1, reg_write=1.
- opcode=1100011, branch_taken=1 then 0 on the next branch -> pc_write=1/pc_src=1 in the first BRANCH, pc_write=0 in the second. Each branch takes 3 cycles.
- opcode=1111111 -> illegal_op pulses in DECODE. Next state FETCH. No reg_write or mem_req in between. retired=0.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> bus_error after 4 wait cycles. mem_req is low for 1 cycle, then FETCH retries.
- rst_n asserted mid-MEM store -> mem_req and mem_we go to 0 immediately (asynchronously). Restart from IDLE. With RV_PERF_CNT_EN, both counters read 0.
